// File: rtl/async_fifo.sv
// Gray-pointer FIFO with two-flop pointer synchronizers, clocked from a single clock.
// The flags are pessimistic, so a later split-clock build can reuse this structure unchanged.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_wr,
  input  logic                  wrst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
  logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
  logic [PW-1:0] wq1_rptr, wq2_rptr;
  logic [PW-1:0] rq1_wptr, rq2_wptr;
  logic          wr_accept, rd_accept;

  assign wr_accept  = wr_en & ~full;
  assign rd_accept  = rd_en & ~empty;

  assign wbin_next  = wbin + PW'(wr_accept);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign rbin_next  = rbin + PW'(rd_accept);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Storage is never reset; its contents only matter once the pointers mark a word as valid.
  always_ff @(posedge clk_wr) begin
    if (wr_accept) begin
      mem[wbin[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Write side: the FIFO is full when the write pointer has lapped the synchronized read pointer.
  always_ff @(posedge clk_wr or posedge wrst) begin
    if (wrst) begin
      wbin     <= '0;
      wgray    <= '0;
      wq1_rptr <= '0;
      wq2_rptr <= '0;
      full     <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= wgray_next;
      wq1_rptr <= rgray;
      wq2_rptr <= wq1_rptr;
      full     <= (wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
    end
  end

  // Read side: the FIFO is empty when the next read pointer meets the synchronized write pointer.
  always_ff @(posedge clk_wr or posedge wrst) begin
    if (wrst) begin
      rbin     <= '0;
      rgray    <= '0;
      rq1_wptr <= '0;
      rq2_wptr <= '0;
      empty    <= 1'b1;
      rd_data  <= '0;
    end else begin
      rbin     <= rbin_next;
      rgray    <= rgray_next;
      rq1_wptr <= wgray;
      rq2_wptr <= rq1_wptr;
      empty    <= (rgray_next == rq2_wptr);
      if (rd_accept) begin
        rd_data <= mem[rbin[ADDR_WIDTH-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Directed testbench for async_fifo: covers reset, single word, fill/overflow, underflow,
// concurrent traffic across a pointer wrap, and a reset issued mid-operation.
module tb_async_fifo;

  logic       clk_wr;
  logic       wrst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;

  int check_count = 0;
  int pass_count  = 0;

  async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk_wr  (clk_wr),
    .wrst    (wrst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  initial begin
    clk_wr = 1'b0;
    forever #5 clk_wr = ~clk_wr;
  end

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_not_empty(input string tag);
    int n;
    n = 0;
    while (empty === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_count++;
    if (empty !== 1'b0) $display("[TB] FAIL %s_wait: empty=%b required 0 within 10 cycles", tag, empty);
    else pass_count++;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      tick();
      check_count++;
      if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b required 1", empty);
      else pass_count++;
      check_count++;
      if (full !== 1'b0) $display("[TB] FAIL reset_full: got %b required 0", full);
      else pass_count++;
      check_count++;
      if (rd_data !== 8'h00) $display("[TB] FAIL reset_rd_data: got %h required 00", rd_data);
      else pass_count++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    wrst  = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    logic exp_empty [4];
    exp_empty = '{1'b1, 1'b1, 1'b1, 1'b0};
    wr_data = 8'hA5;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    check_count++;
    if (empty !== exp_empty[0]) $display("[TB] FAIL single_empty_e0: got %b required %b", empty, exp_empty[0]);
    else pass_count++;
    for (int e = 1; e < 4; e++) begin
      tick();
      check_count++;
      if (empty !== exp_empty[e]) $display("[TB] FAIL single_empty_e%0d: got %b required %b", e, empty, exp_empty[e]);
      else pass_count++;
    end
    tick();
    check_count++;
    if (rd_data !== 8'hA5) $display("[TB] FAIL single_rd_data: got %h required a5", rd_data);
    else pass_count++;
    check_count++;
    if (empty !== 1'b1) $display("[TB] FAIL single_empty_after_read: got %b required 1", empty);
    else pass_count++;
    rd_en = 1'b0;
  endtask

  task automatic test_fill_overflow();
    idle(4);
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(i);
      wr_en   = 1'b1;
      tick();
      check_count++;
      if (full !== (i >= 15)) $display("[TB] FAIL fill_full_w%0d: got %b required %b", i, full, (i >= 15));
      else pass_count++;
    end
    idle(2);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      check_count++;
      if (rd_data !== 8'(i)) $display("[TB] FAIL fill_rd_data_%0d: got %h required %h", i, rd_data, 8'(i));
      else pass_count++;
      check_count++;
      if (empty !== (i == 15)) $display("[TB] FAIL fill_empty_r%0d: got %b required %b", i, empty, (i == 15));
      else pass_count++;
      check_count++;
      if (full !== (i < 3)) $display("[TB] FAIL fill_full_r%0d: got %b required %b", i, full, (i < 3));
      else pass_count++;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_underflow();
    idle(4);
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_count++;
      if (rd_data !== 8'h0F) $display("[TB] FAIL underflow_rd_data_%0d: got %h required 0f", i, rd_data);
      else pass_count++;
      check_count++;
      if (empty !== 1'b1) $display("[TB] FAIL underflow_empty_%0d: got %b required 1", i, empty);
      else pass_count++;
    end
    rd_en   = 1'b0;
    wr_data = 8'h5A;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_not_empty("underflow");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_count++;
    if (rd_data !== 8'h5A) $display("[TB] FAIL underflow_readback: got %h required 5a", rd_data);
    else pass_count++;
  endtask

  task automatic test_concurrent(input int n_words);
    logic [7:0] model [$];
    logic [7:0] exp;
    int written, reads, cyc;
    logic do_rd, do_wr;
    written = 0;
    reads   = 0;
    cyc     = 0;
    idle(4);
    while ((written < n_words || model.size() > 0) && cyc < 200) begin
      do_wr   = (cyc % 2 == 0) && (written < n_words);
      wr_en   = do_wr;
      rd_en   = (cyc % 2 == 1);
      wr_data = 8'($urandom);
      do_rd   = rd_en && (empty === 1'b0);
      check_count++;
      if (full !== 1'b0) $display("[TB] FAIL conc_full_c%0d: got %b required 0", cyc, full);
      else pass_count++;
      check_count++;
      if (empty === 1'b0 && model.size() == 0) $display("[TB] FAIL conc_stale_empty_c%0d: got empty=0 required 1 (model holds 0 words)", cyc);
      else pass_count++;
      tick();
      if (do_rd) begin
        check_count++;
        if (model.size() == 0) begin
          $display("[TB] FAIL conc_extra_read_c%0d: got %h required no data", cyc, rd_data);
        end else begin
          exp = model.pop_front();
          if (rd_data !== exp) $display("[TB] FAIL conc_rd_data_%0d: got %h required %h", reads, rd_data, exp);
          else pass_count++;
        end
        reads++;
      end
      if (do_wr) begin
        model.push_back(wr_data);
        written++;
      end
      cyc++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_count++;
    if (reads !== n_words) $display("[TB] FAIL conc_read_count: got %0d required %0d (cycles %0d)", reads, n_words, cyc);
    else pass_count++;
  endtask

  task automatic test_mid_reset();
    idle(4);
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'h10 + 8'(i);
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    idle(4);
    check_count++;
    if (empty !== 1'b0) $display("[TB] FAIL midrst_pre_empty: got %b required 0", empty);
    else pass_count++;
    #2;
    wrst = 1'b1;
    #1;
    check_count++;
    if (empty !== 1'b1) $display("[TB] FAIL midrst_empty: got %b required 1", empty);
    else pass_count++;
    check_count++;
    if (full !== 1'b0) $display("[TB] FAIL midrst_full: got %b required 0", full);
    else pass_count++;
    check_count++;
    if (rd_data !== 8'h00) $display("[TB] FAIL midrst_rd_data: got %h required 00", rd_data);
    else pass_count++;
    #1;
    wrst = 1'b0;
    idle(2);
    wr_data = 8'h3C;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_not_empty("midrst");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_count++;
    if (rd_data !== 8'h3C) $display("[TB] FAIL midrst_readback: got %h required 3c", rd_data);
    else pass_count++;
    check_count++;
    if (empty !== 1'b1) $display("[TB] FAIL midrst_empty_after_read: got %b required 1", empty);
    else pass_count++;
  endtask

  initial begin
    wrst    = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    #2;
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_underflow();
    test_concurrent(15);
    test_concurrent(15);
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
